// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// FSM state enum and a negate-if-sign helper for the sign fix-up.
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MADD  = 3'd4;
  localparam logic [2:0] MD_MADDU = 3'd5;
  localparam logic [2:0] MD_MSUB  = 3'd6;
  localparam logic [2:0] MD_MSUBU = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Widest value the helper handles. Callers zero-extend into it and
  // truncate the result back to their own width. Two's-complement negation
  // gives the same low bits at any width, so the truncated result is exact.
  localparam int MD_MAX_W = 128;

  function automatic logic [MD_MAX_W-1:0] neg_if(input logic neg,
                                                 input logic [MD_MAX_W-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath, UNROLL bits deep, purely combinational.
// Multiply: {part_hi,part_lo} = {partial product, remaining multiplier bits};
//   each bit conditionally adds the multiplicand into the high half and then
//   shifts the pair right by one.
// Divide: {part_hi,part_lo} = {partial remainder, dividend/quotient bits};
//   each bit performs one restoring step and shifts the quotient bit into the
//   low half.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] part_hi,
  input  logic [XLEN-1:0] part_lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] next_hi,
  output logic [XLEN-1:0] next_lo
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   t;
  logic [XLEN:0]   sum;
  logic            qbit;

  // Chain UNROLL single-bit shift-add or restoring-divide steps.
  always_comb begin
    hi   = part_hi;
    lo   = part_lo;
    t    = '0;
    sum  = '0;
    qbit = 1'b0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div) begin
        t = {hi, lo[XLEN-1]};
        if (t >= {1'b0, operand}) begin
          hi   = XLEN'(t - {1'b0, operand});
          qbit = 1'b1;
        end else begin
          hi   = t[XLEN-1:0];
          qbit = 1'b0;
        end
        lo = {lo[XLEN-2:0], qbit};
      end else begin
        sum = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        hi  = sum[XLEN:1];
        lo  = {sum[0], lo[XLEN-1:1]};
      end
    end
    next_hi = hi;
    next_lo = lo;
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply / divide / multiply-accumulate unit for the EX stage.
// Operands are reduced to magnitudes on acceptance, iterated for XLEN/UNROLL
// cycles, then sign-fixed and optionally accumulated into the latched HI/LO
// during the single DONE cycle. result_o shows the fresh result while done_o
// is high, and holds it afterwards.
// Handshake: an op is accepted on a cycle where the unit is IDLE, start_i=1
// and flush_i=0. stall_o is high from that cycle through the last CALC cycle.
// done_o pulses for one cycle with result_o valid. flush_i aborts without a
// done_o pulse.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [XLEN-1:0]   opa_i,
  input  logic [XLEN-1:0]   opb_i,
  input  logic [2*XLEN-1:0] hilo_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              stall_o,
  output logic              done_o,
  output logic [2*XLEN-1:0] result_o
);

  localparam int ITERS = XLEN / UNROLL;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam int DW    = 2 * XLEN;

  md_state_e         state;
  md_state_e         state_nxt;
  logic [2:0]        op_q;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic [DW-1:0]     hilo_q;
  logic [DW-1:0]     result_q;
  logic [CNT_W-1:0]  cnt;

  logic              accept;
  logic              signed_in;
  logic              is_div_in;
  logic              is_div_q;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   step_hi;
  logic [XLEN-1:0]   step_lo;
  logic [DW-1:0]     prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [DW-1:0]     fix_result;

  assign accept    = (state == MD_IDLE) && start_i && !flush_i;
  assign signed_in = ~op_i[0];
  assign is_div_in = (op_i == MD_DIV) || (op_i == MD_DIVU);
  assign is_div_q  = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign mag_a     = XLEN'(neg_if(signed_in & opa_i[XLEN-1], MD_MAX_W'(opa_i)));
  assign mag_b     = XLEN'(neg_if(signed_in & opb_i[XLEN-1], MD_MAX_W'(opb_i)));

  muldiv_step #(
    .XLEN   (XLEN),
    .UNROLL (UNROLL)
  ) u_step (
    .is_div  (is_div_q),
    .part_hi (hi_q),
    .part_lo (lo_q),
    .operand (opnd_q),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic; flush returns to IDLE from any busy state.
  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (start_i && !flush_i) state_nxt = MD_CALC;
      MD_CALC: begin
        if (flush_i)                    state_nxt = MD_IDLE;
        else if (cnt == CNT_W'(1))      state_nxt = MD_DONE;
      end
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // FSM outputs; stall drops in DONE so EX advances on the done cycle.
  always_comb begin
    busy_o  = (state != MD_IDLE);
    stall_o = accept || (state == MD_CALC);
    done_o  = (state == MD_DONE) && !flush_i;
  end

  // Operand latch on acceptance, iteration in CALC, result capture in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hilo_q   <= '0;
      result_q <= '0;
      cnt      <= '0;
    end else begin
      if (accept) begin
        op_q   <= op_i;
        sign_a <= signed_in & opa_i[XLEN-1];
        sign_b <= signed_in & opb_i[XLEN-1];
        hilo_q <= hilo_i;
        cnt    <= CNT_W'(ITERS);
        hi_q   <= '0;
        // Divide iterates on the dividend with the divisor as operand;
        // multiply iterates on the multiplier with the multiplicand as operand.
        if (is_div_in) begin
          lo_q   <= mag_a;
          opnd_q <= mag_b;
        end else begin
          lo_q   <= mag_b;
          opnd_q <= mag_a;
        end
      end else if (state == MD_CALC) begin
        hi_q <= step_hi;
        lo_q <= step_lo;
        cnt  <= cnt - CNT_W'(1);
      end
      if (done_o) result_q <= fix_result;
    end
  end

  // Sign fix-up and accumulate. A zero divisor leaves the remainder equal to
  // |opa|, so the remainder fix gives back opa unchanged; only LO needs forcing.
  always_comb begin
    prod = DW'(neg_if(sign_a ^ sign_b, MD_MAX_W'({hi_q, lo_q})));
    quot = (opnd_q == '0) ? '1 : XLEN'(neg_if(sign_a ^ sign_b, MD_MAX_W'(lo_q)));
    rem  = XLEN'(neg_if(sign_a, MD_MAX_W'(hi_q)));
    if (is_div_q)     fix_result = {rem, quot};
    else if (op_q[2]) fix_result = op_q[1] ? (hilo_q - prod) : (hilo_q + prod);
    else              fix_result = prod;
  end

  assign result_o = done_o ? fix_result : result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: three instances (UNROLL 1, 2, 4) share stimulus.
// Expected results come from a plain-arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam int XLEN = 32;
  localparam int NU   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [63:0] hilo;
  logic        flush;

  logic        busy   [NU];
  logic        stall  [NU];
  logic        done   [NU];
  logic [63:0] result [NU];

  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_res;

  // clock
  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    localparam int U = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    ex_muldiv_unit #(.XLEN(XLEN), .UNROLL(U)) dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start),
      .op_i     (op),
      .opa_i    (opa),
      .opb_i    (opb),
      .hilo_i   (hilo),
      .flush_i  (flush),
      .busy_o   (busy[g]),
      .stall_o  (stall[g]),
      .done_o   (done[g]),
      .result_o (result[g])
    );
  end

  function automatic int unroll_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  function automatic int lat_of(input int i);
    return XLEN / unroll_of(i) + 1;
  endfunction

  // reference model: plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint sa;
    longint sb;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return up;
      3'd2: if (b == 0) return {a, 32'hFFFF_FFFF};
            else return {32'(sa % sb), 32'(sa / sb)};
      3'd3: if (b == 0) return {a, 32'hFFFF_FFFF};
            else return {a % b, a / b};
      3'd4: return hl + 64'(sa * sb);
      3'd5: return hl + up;
      3'd6: return hl - 64'(sa * sb);
      default: return hl - up;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; opa = '0; opb = '0; hilo = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NU; i++) begin
      checks++;
      if (busy[i] !== 1'b0 || stall[i] !== 1'b0 || done[i] !== 1'b0 || result[i] !== 64'h0) begin
        errors++;
        $display("FAIL reset[u%0d]: busy=%b stall=%b done=%b result=%h, want 0 0 0 0",
                 unroll_of(i), busy[i], stall[i], done[i], result[i]);
      end
    end
    rst = 1'b0;
    last_res = '0;
  endtask

  // Issue one op and watch every instance for 40 cycles.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] hl, input bit pulse_mid);
    logic [63:0] exp_v;
    int          n_done [NU];
    int          at     [NU];
    logic [63:0] got    [NU];
    exp_v = model(o, a, b, hl);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; hilo = hl;
    #1;
    for (int i = 0; i < NU; i++) begin
      checks++;
      if (stall[i] !== 1'b1) begin
        errors++;
        $display("FAIL %s accept_stall[u%0d]: got %b want 1", name, unroll_of(i), stall[i]);
      end
      n_done[i] = 0; at[i] = -1; got[i] = '0;
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < NU; i++) begin
        if (done[i] === 1'b1) begin
          n_done[i]++; at[i] = c; got[i] = result[i];
          checks++;
          if (stall[i] !== 1'b0) begin
            errors++;
            $display("FAIL %s done_stall[u%0d]: got %b want 0", name, unroll_of(i), stall[i]);
          end
        end
      end
      if (c == 1) start = 1'b0;
      if (pulse_mid && c == 3) begin
        start = 1'b1; op = 3'd1; opa = $urandom; opb = $urandom; hilo = {$urandom, $urandom};
      end
      if (pulse_mid && c == 4) start = 1'b0;
    end
    for (int i = 0; i < NU; i++) begin
      checks++;
      if (n_done[i] != 1 || at[i] != lat_of(i)) begin
        errors++;
        $display("FAIL %s done_count_latency[u%0d]: got %0d pulses at cycle %0d, want 1 at %0d",
                 name, unroll_of(i), n_done[i], at[i], lat_of(i));
      end
      checks++;
      if (got[i] !== exp_v) begin
        errors++;
        $display("FAIL %s result[u%0d]: got %h want %h", name, unroll_of(i), got[i], exp_v);
      end
      checks++;
      if (result[i] !== exp_v || busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL %s hold[u%0d]: result=%h busy=%b want %h 0", name, unroll_of(i),
                 result[i], busy[i], exp_v);
      end
    end
    last_res = exp_v;
  endtask

  task automatic test_directed();
    run_op("mult_neg",  3'd0, 32'hFFFF_FFFF, 32'h2, 64'h0, 1'b0);
    run_op("multu",     3'd1, 32'hFFFF_FFFF, 32'h2, 64'h0, 1'b0);
    run_op("madd",      3'd4, 32'd3, 32'd4, 64'h10, 1'b0);
    run_op("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2, 64'h0, 1'b0);
    run_op("divu",      3'd3, 32'd7, 32'd2, 64'h0, 1'b0);
    run_op("divu_zero", 3'd3, 32'd5, 32'd0, 64'h0, 1'b0);
    run_op("div_zero",  3'd2, 32'hFFFF_FFFB, 32'd0, 64'h0, 1'b0);
    run_op("div_min",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0, 1'b0);
    run_op("msubu",     3'd7, 32'd1, 32'd1, 64'h0, 1'b0);
    run_op("msub",      3'd6, 32'hFFFF_FFFE, 32'd5, 64'h1234, 1'b0);
  endtask

  task automatic test_mid_start();
    run_op("mid_start", 3'd0, 32'd1234, 32'hFFFF_FF00, 64'h0, 1'b1);
  endtask

  task automatic test_flush();
    int n_done [NU];
    for (int i = 0; i < NU; i++) n_done[i] = 0;
    @(negedge clk);
    start = 1'b1; op = 3'd2; opa = $urandom; opb = $urandom_range(1, 1000);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < NU; i++) begin
        if (done[i] === 1'b1) n_done[i]++;
        if (c == 6) begin
          checks++;
          if (busy[i] !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy[u%0d]: got %b want 0", unroll_of(i), busy[i]);
          end
        end
      end
      if (c == 1) start = 1'b0;
      if (c == 5) flush = 1'b1;
      if (c == 6) flush = 1'b0;
    end
    for (int i = 0; i < NU; i++) begin
      checks++;
      if (n_done[i] != 0 || result[i] !== last_res) begin
        errors++;
        $display("FAIL flush_result[u%0d]: %0d pulses result=%h, want 0 pulses %h",
                 unroll_of(i), n_done[i], result[i], last_res);
      end
    end
    // start together with flush in IDLE is not accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd1; opa = 32'd9; opb = 32'd9;
    #1;
    for (int i = 0; i < NU; i++) begin
      checks++;
      if (stall[i] !== 1'b0) begin
        errors++;
        $display("FAIL flush_idle_stall[u%0d]: got %b want 0", unroll_of(i), stall[i]);
      end
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    for (int i = 0; i < NU; i++) begin
      checks++;
      if (busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL flush_idle_busy[u%0d]: got %b want 0", unroll_of(i), busy[i]);
      end
    end
    run_op("mult_after_flush", 3'd0, 32'd6, 32'd7, 64'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n_done [NU];
    for (int i = 0; i < NU; i++) n_done[i] = 0;
    @(negedge clk);
    start = 1'b1; op = 3'd0; opa = $urandom; opb = $urandom;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < NU; i++) begin
        if (done[i] === 1'b1) n_done[i]++;
        if (c == 6) begin
          checks++;
          if (busy[i] !== 1'b0 || stall[i] !== 1'b0 || done[i] !== 1'b0 || result[i] !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid[u%0d]: busy=%b stall=%b done=%b result=%h, want 0 0 0 0",
                     unroll_of(i), busy[i], stall[i], done[i], result[i]);
          end
        end
      end
      if (c == 1) start = 1'b0;
      if (c == 5) rst = 1'b1;
      if (c == 6) rst = 1'b0;
    end
    for (int i = 0; i < NU; i++) begin
      checks++;
      if (n_done[i] != 0) begin
        errors++;
        $display("FAIL reset_mid_done[u%0d]: got %0d pulses want 0", unroll_of(i), n_done[i]);
      end
    end
    last_res = '0;
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    for (int n = 0; n < 30; n++) begin
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op("random", o, a, b, {$urandom, $urandom}, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mid_start();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
